lcd_sum_formatter: RTL and testbench
====================================

// Module: lcd_sum_formatter
// PURPOSE
//  Upstream feeder for the HD44780 character-LCD writer. Snapshots operands a and b,
//  computes a+b, converts all three to decimal ASCII by sequential repeated subtraction,
//  and streams one position command plus the text "AA+BB=SSS" over a valid/ready link.
//  The LCD writer consumes each item {rs,data} and handles its own EN timing.
// PARAMETERS
//  WIDTH         5   operand width in bits; legal 1..6 (sum <= 126, so 3 sum digits suffice)
//  POS_CMD       8'h80  command byte sent first (set DDRAM addr: line 1, col 0)
//  AUTO_REFRESH  0   1 = start a conversion on its own when a/b differ from the last snapshot
// PORTS
//  clk        in   1      system clock, all logic on posedge
//  rst        in   1      synchronous, active-high reset
//  a          in   WIDTH  operand A, unsigned
//  b          in   WIDTH  operand B, unsigned
//  start      in   1      request conversion; sampled only in IDLE
//  out_data   out  8      command byte or ASCII character
//  out_rs     out  1      0 = command, 1 = character data (drives LCD RS)
//  out_valid  out  1      out_data/out_rs hold a valid item
//  out_ready  in   1      consumer accepts the item this cycle
//  busy       out  1      high from capture until the final item is accepted
//  done       out  1      one-cycle pulse after the final item is accepted
// BEHAVIOUR
//  Reset: state=IDLE; out_valid=0, out_data=0, out_rs=0, busy=0, done=0; snapshot regs=0.
//  FSM states: IDLE -> CAPTURE -> CONV_A -> CONV_B -> CONV_S -> EMIT -> IDLE.
//  IDLE: if start=1 (or AUTO_REFRESH=1 and {a,b} != snapshot), go to CAPTURE; busy=1 next cycle.
//  CAPTURE: latch a, b, and sum=a+b at WIDTH+1 bits, zero-extended (no overflow possible).
//  CONV_x: one subtraction per cycle: subtract 100 while >=100 (hundreds++), then subtract 10
//   while >=10 (tens++); the remainder is ones. Then advance to the next operand.
//  First out_valid occurs no more than 40 cycles after the start is sampled, for any legal input.
//  Item sequence (10 items): POS_CMD(rs=0); then A tens, A ones, '+'(8'h2B), B tens, B ones,
//   '='(8'h3D), S hundreds, S tens, S ones, all with rs=1.
//  Digits are 8'h30+digit. Leading zeros are printed, never blanked.
//  Handshake: an item transfers on a cycle with out_valid&&out_ready.
//  While out_valid&&!out_ready, out_data and out_rs are held stable. out_valid never drops
//   without a transfer. The next item may present on the cycle after a transfer (1 item/cycle max).
//  out_valid is asserted only in EMIT. out_ready is ignored when out_valid=0.
//  After the 10th transfer: out_valid=0, busy=0, done=1 for exactly one cycle, state=IDLE.
//  start asserted while busy is ignored (not queued). Changes to a/b after CAPTURE do not
//   affect the current stream. With AUTO_REFRESH, a change during busy is picked up in IDLE.
//  rst during any state: on the next cycle all outputs are at reset values, the stream is
//   abandoned, and no done pulse occurs. The next conversion restarts from POS_CMD.
// TESTING
//  1. WIDTH=5, a=12, b=7, start pulse, out_ready=1 -> items {0,80} {1,31}{1,32}{1,2B}
//     {1,30}{1,37}{1,3D}{1,30}{1,31}{1,39}, then done pulse and busy=0.
//  2. a=31, b=31 -> text "31+31=062"; a=0, b=0 -> "00+00=000".
//  3. WIDTH=6, a=63, b=63 -> "63+63=126". First out_valid <=40 cycles after start.
//  4. Random out_ready backpressure over 100 conversions -> each stream is exactly 10 items
//     in order, stable while stalled, with no drops or duplicates.
//  5. start pulsed and a/b changed mid-EMIT -> ignored. Stream matches the snapshot; one done.
//  6. rst asserted at item 5 -> next cycle out_valid=0, busy=0, done=0. A new start gives
//     the full 10-item stream. AUTO_REFRESH=1: changing b in IDLE triggers a stream with no start.

Source files
------------

// File: rtl/lcd_sum_formatter_if.sv
// rtl/lcd_sum_formatter_if.sv - valid/ready item link from the sum formatter to the LCD writer
// Purpose: carries one {rs,data} item per transfer; a transfer occurs when out_valid && out_ready.
// Signals:
//   out_data  [7:0]  command byte or ASCII character (master -> slave)
//   out_rs           0 = command, 1 = character data  (master -> slave)
//   out_valid        item present                      (master -> slave)
//   out_ready        consumer accepts item this cycle  (slave -> master)
interface lcd_sum_formatter_if;
  logic [7:0] out_data;
  logic       out_rs;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_data, output out_rs, output out_valid, input out_ready);
  modport slave  (input out_data, input out_rs, input out_valid, output out_ready);
endinterface

// File: rtl/lcd_sum_formatter.sv
// rtl/lcd_sum_formatter.sv - formats "AA+BB=SSS" plus a position command for the HD44780 writer
// Purpose: snapshots a and b, forms a+b, converts each value to decimal digits by repeated
//   subtraction (one step per cycle) and streams 10 items: POS_CMD, then the text.
// Ports:
//   clk    in   system clock (posedge)
//   rst    in   synchronous active-high reset
//   a, b   in   unsigned operands, WIDTH bits (WIDTH legal 1..6)
//   start  in   conversion request, sampled only while idle
//   lcd    master modport: out_data/out_rs/out_valid out, out_ready in
//   busy   out  high from capture until the final item is accepted
//   done   out  one-cycle pulse after the final item is accepted
module lcd_sum_formatter #(
  parameter int         WIDTH        = 5,
  parameter logic [7:0] POS_CMD      = 8'h80,
  parameter bit         AUTO_REFRESH = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 start,
  lcd_sum_formatter_if.master  lcd,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [2:0] {IDLE, CAPTURE, CONV_A, CONV_B, CONV_S, EMIT} state_t;

  state_t           state;
  logic [WIDTH-1:0] snap_a;
  logic [WIDTH-1:0] snap_b;
  logic [WIDTH:0]   snap_s;
  logic [6:0]       work;      // value being decomposed; 7 bits covers the largest sum (126)
  logic [3:0]       hund;
  logic [3:0]       tens;
  logic [3:0]       a_t, a_o, b_t, b_o, s_h, s_t, s_o;
  logic [3:0]       idx;       // index of the item currently presented
  logic             trigger;
  logic [8:0]       next_item; // {rs,data} for item idx+1

  // Auto refresh compares live inputs against the last snapshot, so a change made
  // while busy is picked up once the FSM is back in IDLE.
  assign trigger = start || (AUTO_REFRESH && ({a, b} != {snap_a, snap_b}));

  function automatic logic [7:0] ascii(input logic [3:0] d);
    return 8'h30 + {4'h0, d};
  endfunction

  always_comb begin
    next_item = {1'b0, POS_CMD};
    case (idx)
      4'd0: next_item = {1'b1, ascii(a_t)};
      4'd1: next_item = {1'b1, ascii(a_o)};
      4'd2: next_item = {1'b1, 8'h2B};
      4'd3: next_item = {1'b1, ascii(b_t)};
      4'd4: next_item = {1'b1, ascii(b_o)};
      4'd5: next_item = {1'b1, 8'h3D};
      4'd6: next_item = {1'b1, ascii(s_h)};
      4'd7: next_item = {1'b1, ascii(s_t)};
      4'd8: next_item = {1'b1, ascii(s_o)};
      default: next_item = {1'b0, POS_CMD};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      snap_a        <= '0;
      snap_b        <= '0;
      snap_s        <= '0;
      work          <= '0;
      hund          <= '0;
      tens          <= '0;
      a_t           <= '0;
      a_o           <= '0;
      b_t           <= '0;
      b_o           <= '0;
      s_h           <= '0;
      s_t           <= '0;
      s_o           <= '0;
      idx           <= '0;
      lcd.out_data  <= '0;
      lcd.out_rs    <= 1'b0;
      lcd.out_valid <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (trigger) begin
            busy  <= 1'b1;
            state <= CAPTURE;
          end
        end

        CAPTURE: begin
          snap_a <= a;
          snap_b <= b;
          snap_s <= {1'b0, a} + {1'b0, b};
          work   <= 7'(a);
          hund   <= '0;
          tens   <= '0;
          state  <= CONV_A;
        end

        CONV_A, CONV_B, CONV_S: begin
          if (work >= 7'd100) begin
            work <= work - 7'd100;
            hund <= hund + 4'd1;
          end else if (work >= 7'd10) begin
            work <= work - 7'd10;
            tens <= tens + 4'd1;
          end else begin
            // Digit extraction finished for this value; hand over to the next one.
            hund <= '0;
            tens <= '0;
            case (state)
              CONV_A: begin
                a_t   <= tens;
                a_o   <= work[3:0];
                work  <= 7'(snap_b);
                state <= CONV_B;
              end
              CONV_B: begin
                b_t   <= tens;
                b_o   <= work[3:0];
                work  <= 7'(snap_s);
                state <= CONV_S;
              end
              default: begin
                s_h           <= hund;
                s_t           <= tens;
                s_o           <= work[3:0];
                idx           <= '0;
                lcd.out_data  <= POS_CMD;
                lcd.out_rs    <= 1'b0;
                lcd.out_valid <= 1'b1;
                state         <= EMIT;
              end
            endcase
          end
        end

        EMIT: begin
          // Item registers only move on a transfer, so they hold while stalled.
          if (lcd.out_valid && lcd.out_ready) begin
            if (idx == 4'd9) begin
              lcd.out_valid <= 1'b0;
              busy          <= 1'b0;
              done          <= 1'b1;
              state         <= IDLE;
            end else begin
              idx          <= idx + 4'd1;
              lcd.out_rs   <= next_item[8];
              lcd.out_data <= next_item[7:0];
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_sum_formatter.sv
// tb/tb_lcd_sum_formatter.sv - directed bench for lcd_sum_formatter (W5, W6, W5 auto refresh)
module tb_lcd_sum_formatter;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] a_v [3];
  logic [5:0] b_v [3];
  logic       start_v [3];
  logic       rdy [3];
  logic       vld [3];
  logic       rs [3];
  logic [7:0] dat [3];
  logic       busy_v [3];
  logic       done_v [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lcd_sum_formatter_if bus0 ();
  lcd_sum_formatter_if bus1 ();
  lcd_sum_formatter_if bus2 ();

  assign bus0.out_ready = rdy[0];
  assign bus1.out_ready = rdy[1];
  assign bus2.out_ready = rdy[2];
  assign vld[0] = bus0.out_valid;
  assign vld[1] = bus1.out_valid;
  assign vld[2] = bus2.out_valid;
  assign rs[0]  = bus0.out_rs;
  assign rs[1]  = bus1.out_rs;
  assign rs[2]  = bus2.out_rs;
  assign dat[0] = bus0.out_data;
  assign dat[1] = bus1.out_data;
  assign dat[2] = bus2.out_data;

  lcd_sum_formatter #(.WIDTH(5), .POS_CMD(8'h80), .AUTO_REFRESH(1'b0)) u0 (
    .clk(clk), .rst(rst), .a(a_v[0][4:0]), .b(b_v[0][4:0]), .start(start_v[0]),
    .lcd(bus0.master), .busy(busy_v[0]), .done(done_v[0]));

  lcd_sum_formatter #(.WIDTH(6), .POS_CMD(8'h80), .AUTO_REFRESH(1'b0)) u1 (
    .clk(clk), .rst(rst), .a(a_v[1]), .b(b_v[1]), .start(start_v[1]),
    .lcd(bus1.master), .busy(busy_v[1]), .done(done_v[1]));

  lcd_sum_formatter #(.WIDTH(5), .POS_CMD(8'h80), .AUTO_REFRESH(1'b1)) u2 (
    .clk(clk), .rst(rst), .a(a_v[2][4:0]), .b(b_v[2][4:0]), .start(start_v[2]),
    .lcd(bus2.master), .busy(busy_v[2]), .done(done_v[2]));

  // Called on a falling edge; start (or an input change) is sampled on the next rising edge.
  task automatic kick(input int sel, input int av, input int bv, input bit use_start);
    a_v[sel]     = 6'(av);
    b_v[sel]     = 6'(bv);
    start_v[sel] = use_start;
    @(negedge clk);
    start_v[sel] = 1'b0;
    checks++;
    if (busy_v[sel] !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_start dut%0d got %b want 1", sel, busy_v[sel]);
    end
  endtask

  // Consumes one stream and checks every item against txt. abort_at >= 0 stops after
  // that many transfers without checking the ending; disturb pokes start/a/b mid-EMIT.
  task automatic run_stream(input int sel, input string txt, input bit bp,
                            input bit disturb, input int abort_at);
    int         n;
    int         got;
    bit         stalled;
    bit         poked;
    logic [8:0] held;
    logic [8:0] exp;
    n = 0; got = 0; stalled = 0; poked = 0; held = '0;
    rdy[sel] = 1'b0;
    while (vld[sel] !== 1'b1 && n < 45) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (vld[sel] !== 1'b1 || n > 40) begin
      errors++;
      $display("FAIL first_valid_latency dut%0d got %0d cycles want <=40", sel, n);
    end
    n = 0;
    while (got < 10 && got != abort_at && n < 2000) begin
      if (poked) begin
        start_v[sel] = 1'b0;
      end
      if (disturb && got == 4 && !poked) begin
        a_v[sel] = 6'd17; b_v[sel] = 6'd3; start_v[sel] = 1'b1; poked = 1;
      end
      if (stalled) begin
        checks++;
        if (vld[sel] !== 1'b1 || {rs[sel], dat[sel]} !== held) begin
          errors++;
          $display("FAIL stall_hold dut%0d item %0d got v=%b %h want v=1 %h",
                   sel, got, vld[sel], {rs[sel], dat[sel]}, held);
        end
      end
      rdy[sel] = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled = 0;
      if (vld[sel] === 1'b1) begin
        if (rdy[sel]) begin
          exp = (got == 0) ? {1'b0, 8'h80} : {1'b1, txt[got-1]};
          checks++;
          if ({rs[sel], dat[sel]} !== exp) begin
            errors++;
            $display("FAIL item dut%0d idx %0d got %h want %h", sel, got, {rs[sel], dat[sel]}, exp);
          end
          got++;
        end else begin
          stalled = 1;
          held = {rs[sel], dat[sel]};
        end
      end
      @(negedge clk);
      n++;
    end
    rdy[sel]     = 1'b0;
    start_v[sel] = 1'b0;
    if (got == abort_at) return;
    checks++;
    if (got != 10) begin
      errors++;
      $display("FAIL stream_timeout dut%0d got %0d items want 10", sel, got);
    end
    checks++;
    if (done_v[sel] !== 1'b1 || busy_v[sel] !== 1'b0 || vld[sel] !== 1'b0) begin
      errors++;
      $display("FAIL end_of_stream dut%0d got done=%b busy=%b valid=%b want 1 0 0",
               sel, done_v[sel], busy_v[sel], vld[sel]);
    end
    @(negedge clk);
    checks++;
    if (done_v[sel] !== 1'b0) begin
      errors++;
      $display("FAIL done_single_cycle dut%0d got %b want 0", sel, done_v[sel]);
    end
  endtask

  task automatic expect_quiet(input int sel, input string name);
    int seen;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (vld[sel] === 1'b1 || busy_v[sel] === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL %s dut%0d got %0d active cycles want 0", name, sel, seen);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (vld[s] !== 1'b0 || dat[s] !== 8'h00 || rs[s] !== 1'b0 ||
          busy_v[s] !== 1'b0 || done_v[s] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state dut%0d got v=%b d=%h rs=%b busy=%b done=%b want all 0",
                 s, vld[s], dat[s], rs[s], busy_v[s], done_v[s]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    expect_quiet(2, "auto_idle_after_reset");
  endtask

  task automatic test_basic;
    kick(0, 12, 7, 1);
    run_stream(0, "12+07=019", 0, 0, -1);
  endtask

  task automatic test_values;
    kick(0, 31, 31, 1);
    run_stream(0, "31+31=062", 0, 0, -1);
    kick(0, 0, 0, 1);
    run_stream(0, "00+00=000", 0, 0, -1);
  endtask

  task automatic test_width6;
    kick(1, 63, 63, 1);
    run_stream(1, "63+63=126", 0, 0, -1);
    kick(1, 40, 9, 1);
    run_stream(1, "40+09=049", 1, 0, -1);
  endtask

  task automatic test_backpressure;
    int av;
    int bv;
    for (int k = 0; k < 100; k++) begin
      av = int'($urandom_range(0, 31));
      bv = int'($urandom_range(0, 31));
      kick(0, av, bv, 1);
      run_stream(0, $sformatf("%02d+%02d=%03d", av, bv, av + bv), 1, 0, -1);
    end
  endtask

  task automatic test_mid_emit;
    kick(0, 5, 9, 1);
    run_stream(0, "05+09=014", 0, 1, -1);
    expect_quiet(0, "no_restart_after_ignored_start");
  endtask

  task automatic test_reset_mid;
    kick(0, 23, 18, 1);
    run_stream(0, "23+18=041", 0, 0, 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (vld[0] !== 1'b0 || busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_stream got v=%b busy=%b done=%b want 0 0 0",
               vld[0], busy_v[0], done_v[0]);
    end
    expect_quiet(0, "abandoned_stream_stays_idle");
    kick(0, 23, 18, 1);
    run_stream(0, "23+18=041", 0, 0, -1);
  endtask

  task automatic test_auto_refresh;
    kick(2, 0, 3, 0);
    run_stream(2, "00+03=003", 0, 0, -1);
    expect_quiet(2, "auto_no_retrigger");
    kick(2, 29, 3, 0);
    run_stream(2, "29+03=032", 1, 0, -1);
  endtask

  initial begin
    rst = 1'b1;
    for (int s = 0; s < 3; s++) begin
      a_v[s] = '0; b_v[s] = '0; start_v[s] = 1'b0; rdy[s] = 1'b0;
    end
    test_reset;
    test_basic;
    test_values;
    test_width6;
    test_backpressure;
    test_mid_emit;
    test_reset_mid;
    test_auto_refresh;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
